// File: rtl/event_encoder.sv
// -----------------------------------------------------------------------------
// event_encoder
//
// Collects single-cycle event pulses on N request lines into a sticky pending
// register. It then emits the events one at a time as binary indices over a
// valid/ready stream. An event that arrives on a line which is already pending
// merges with the earlier one, and the overflow output pulses for one cycle.
//
// Optional feature macro: EVENT_ENC_RR_EN
//   undefined : fixed priority, the lowest pending index wins
//   defined   : round-robin selection starting at a pointer that advances
//               past each loaded index
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [N]     event pulses, one event per set bit per cycle
//   out_valid  out  1       output slot holds an index
//   out_ready  in   1       consumer accepts the index this cycle
//   out_idx    out  [IDX_W] index presented in the slot
//   pending    out  [N]     captured events not yet loaded into the slot
//   overflow   out  1       pulse: an event merged into an already-pending line
// -----------------------------------------------------------------------------
module event_encoder #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    logic [N-1:0]     r_pending;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_overflow;

    logic             w_slot_free;
    logic             w_load;
    logic [IDX_W-1:0] w_winner;
    logic [N-1:0]     w_load_mask;
    logic [N-1:0]     w_pending_next;
    logic             w_overflow_next;

`ifdef EVENT_ENC_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
`endif

    // The slot can take a new index when it is empty or is being drained.
    assign w_slot_free = ~r_valid | out_ready;
    assign w_load      = w_slot_free & (|r_pending);

    // The scan runs from the highest offset down to the lowest, so the last
    // hit is the first set bit in the scan order.
    always_comb begin
        w_winner = '0;
`ifdef EVENT_ENC_RR_EN
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = r_ptr + IDX_W'(k);   // wraps modulo N because N is a power of two
            if (r_pending[w_cand]) begin
                w_winner = w_cand;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_winner = IDX_W'(k);
            end
        end
`endif
    end

    assign w_load_mask = w_load ? (N'(1) << w_winner) : '0;

    // A new event on a line wins over the clear of that line's pending bit.
    // An index that is loaded this cycle has left pending, so a new event on
    // that line re-arms the line without counting as a merge.
    assign w_pending_next  = (r_pending & ~w_load_mask) | req;
    assign w_overflow_next = |(req & r_pending & ~w_load_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            if (w_slot_free) begin
                r_valid <= w_load;
                if (w_load) begin
                    r_idx <= w_winner;
                end
            end
        end
    end

`ifdef EVENT_ENC_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= w_winner + IDX_W'(1);
        end
    end
`endif

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_event_encoder.sv
module tb_event_encoder;

    localparam int N     = 16;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [N-1:0]     pending;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state. The model works on plain integers and scans.
    logic [N-1:0] m_pend;
    bit           m_valid;
    int           m_idx;
    bit           m_ovf;
    int           m_ptr;

    event_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic model_clock(input logic [N-1:0] r, input bit rdy);
        int w;
        bit free;
        logic [N-1:0] nxt;
        w    = -1;
        free = !m_valid || rdy;
        if (free) begin
            for (int k = 0; k < N; k++) begin
`ifdef EVENT_ENC_RR_EN
                int j;
                j = (m_ptr + k) % N;
`else
                int j;
                j = k;
`endif
                if (w < 0 && m_pend[j]) w = j;
            end
        end
        nxt   = m_pend;
        m_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && m_pend[i] && i != w) m_ovf = 1'b1;
        end
        if (w >= 0) nxt[w] = 1'b0;
        m_pend = nxt | r;
        if (free) begin
            m_valid = (w >= 0);
            if (w >= 0) begin
                m_idx = w;
                m_ptr = (w + 1) % N;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    32'(out_valid), 32'(m_valid));
        chk({tag, ".idx"},      32'(out_idx),   32'(m_idx));
        chk({tag, ".pending"},  32'(pending),   32'(m_pend));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    // Inputs are applied 1 unit after a rising edge. The outputs are checked
    // 1 unit after the next rising edge.
    task automatic step(input logic [N-1:0] r, input bit rdy, input string tag);
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_clock(r, rdy);
        #1;
        check_model(tag);
    endtask

    // The reset is applied in the middle of a cycle so that its asynchronous
    // effect can be seen before any clock edge.
    task automatic mid_reset(input string tag);
        #2;
        req   = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #12;
        check_model("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-stream with pending=00F0 and valid=1
        step(16'h0001, 1'b0, "t1a");
        step(16'h00F0, 1'b0, "t1b");
        chk("t1.pre_pend",  32'(pending),   32'h00F0);
        chk("t1.pre_valid", 32'(out_valid), 32'd1);
        mid_reset("t1.rst");
        chk("t1.pend0",  32'(pending),   32'd0);
        chk("t1.valid0", 32'(out_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step('0, 1'b1, "t1.after");
            chk("t1.no_stale", 32'(out_valid), 32'd0);
        end

        // Single event latency
        step(16'h0001, 1'b1, "t2.c1");
        chk("t2.pend_t1", 32'(pending), 32'h0001);
        step('0, 1'b1, "t2.c2");
        chk("t2.valid_t2", 32'(out_valid), 32'd1);
        chk("t2.idx_t2",   32'(out_idx),   32'd0);
        step('0, 1'b1, "t2.c3");
        chk("t2.valid_t3", 32'(out_valid), 32'd0);

        // Drain of several events in index order
        mid_reset("t3.rst");
        step(16'h8421, 1'b1, "t3.c1");
        begin
            int          exp_idx [4]  = '{0, 5, 10, 15};
            logic [15:0] exp_pend [4] = '{16'h8420, 16'h8400, 16'h8000, 16'h0000};
            for (int c = 0; c < 4; c++) begin
                step('0, 1'b1, "t3.drain");
                chk("t3.idx",  32'(out_idx), 32'(exp_idx[c]));
                chk("t3.pend", 32'(pending), 32'(exp_pend[c]));
            end
        end

        // Slot stays stable under back-pressure
        mid_reset("t4.rst");
        step(16'h0020, 1'b0, "t4.a");
        step('0, 1'b0, "t4.b");
        step(16'h0001, 1'b0, "t4.c");
        chk("t4.hold1", 32'(out_idx), 32'd5);
        step('0, 1'b0, "t4.d");
        chk("t4.hold2", 32'(out_idx), 32'd5);
        step('0, 1'b1, "t4.e");
        chk("t4.next_idx",   32'(out_idx),   32'd0);
        chk("t4.next_valid", 32'(out_valid), 32'd1);

        // Merge into a pending line raises overflow once
        mid_reset("t5.rst");
        step(16'h0004, 1'b0, "t5.a");
        step('0, 1'b0, "t5.b");
        step(16'h0008, 1'b0, "t5.c");
        chk("t5.ovf0", 32'(overflow), 32'd0);
        step(16'h0008, 1'b0, "t5.d");
        chk("t5.ovf1", 32'(overflow), 32'd1);
        step('0, 1'b0, "t5.e");
        chk("t5.ovf_end", 32'(overflow), 32'd0);
        chk("t5.idx2",    32'(out_idx),  32'd2);
        step('0, 1'b1, "t5.f");
        chk("t5.idx3", 32'(out_idx), 32'd3);
        step('0, 1'b1, "t5.g");
        chk("t5.once", 32'(out_valid), 32'd0);

        // Two lines held active continuously
        mid_reset("t6.rst");
        for (int c = 1; c <= 6; c++) begin
            step(16'h0003, 1'b1, "t6");
            if (c >= 2) begin
`ifdef EVENT_ENC_RR_EN
                chk("t6.rr_idx", 32'(out_idx), 32'((c - 2) % 2));
`else
                chk("t6.fixed_idx", 32'(out_idx), 32'd0);
                chk("t6.starve_ovf", 32'(overflow), 32'd1);
`endif
            end
        end

        // Randomized traffic against the model
        mid_reset("rnd.rst");
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] r;
            bit rdy;
            r   = N'($urandom) & N'($urandom) & N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if (c % 500 == 250) r = N'($urandom);
            step(r, rdy, "rnd");
            if (c == 1200) mid_reset("rnd.midrst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
